// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: reset/enable levels, register bus widths,
// default FIFO depth and starvation limit, and the write-port source select.
package wb_arbiter_pkg;
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam int   REG_AW        = 5;
    localparam int   REG_DW        = 32;
    localparam int   WB_FIFO_DEPTH = 4;
    localparam int   WB_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Write-back FIFO: circular buffer of {waddr, wdata} with count-based full/empty
// and a per-entry destination compare that yields the decode pending flags.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          pend1,
    output logic          pend2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] occupied;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (addr_q[i] == raddr1)) pend1 = 1'b1;
            if (occupied[i] && (addr_q[i] == raddr2)) pend2 = 1'b1;
        end
        if (raddr1 == '0) pend1 = 1'b0;
        if (raddr2 == '0) pend2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency
// results queue in wb_fifo and drain on idle cycles. WB_STARVE_EN adds stall_req.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = WB_FIFO_DEPTH,
    parameter int AW         = REG_AW,
    parameter int DW         = REG_DW,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          lr_valid,
    output logic          lr_ready,
    input  logic [AW-1:0] lr_waddr,
    input  logic [DW-1:0] lr_wdata,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          pend1,
    output logic          pend2,
    output logic          stall_req
);
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_params
        $error("wb_arbiter: DEPTH must be a power of two in 2..16 and STARVE_MAX at least 1");
    end

    logic          in_rst;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          fifo_pend1;
    logic          fifo_pend2;
    wb_src_e       src;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    assign in_rst    = (rst == RST_ENABLE);
    assign lr_ready  = !in_rst && !fifo_full;
    // A zero destination completes the handshake but has nothing to write.
    assign fifo_push = lr_valid && lr_ready && (lr_waddr != '0);
    assign fifo_pop  = (src == SRC_FIFO);
    assign pend1     = fifo_pend1 && !in_rst;
    assign pend2     = fifo_pend2 && !in_rst;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_addr (lr_waddr),
        .push_data (lr_wdata),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .pend1     (fifo_pend1),
        .pend2     (fifo_pend2)
    );

    // A pipeline write to r0 is a no-op, so the FIFO head may use that slot.
    always_comb begin
        src = SRC_NONE;
        if (in_rst) begin
            src = SRC_NONE;
        end else if (pipe_we && (pipe_waddr != '0)) begin
            src = SRC_PIPE;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (pipe_we) begin
            src = SRC_PIPE;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (src)
            SRC_PIPE: begin
                sel_addr = pipe_waddr;
                sel_data = pipe_wdata;
            end
            SRC_FIFO: begin
                sel_addr = head_addr;
                sel_data = head_data;
            end
            default: begin
                sel_addr = '0;
                sel_data = '0;
            end
        endcase
        we    = ((src != SRC_NONE) && (sel_addr != '0)) ? WRITE_ENABLE : !WRITE_ENABLE;
        waddr = sel_addr;
        wdata = sel_data;
    end

`ifdef WB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    // Counts consecutive cycles the head waited behind a pipeline write.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (pipe_we && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_req = stall_q && !in_rst;
`else
    assign stall_req = 1'b0;
`endif
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter in front of the register file's single write port. Merges the in-order pipeline write-back (zero latency, highest priority) with results from long-latency units (divider, uncached loads). Those results are buffered in a small FIFO and drained on cycles when the pipeline does not write. Also provides pending-write flags so decode can stall on RAW/WAW hazards against buffered results.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- AW, 5, register address width
- DW, 32, data width
- STARVE_MAX, 8, consecutive blocked-drain cycles before a stall request

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- pipe_we  in  1  pipeline write-back valid
- pipe_waddr  in  AW  pipeline destination
- pipe_wdata  in  DW  pipeline result
- lr_valid  in  1  long-latency result offered
- lr_ready  out  1  FIFO can accept
- lr_waddr  in  AW  long-latency destination
- lr_wdata  in  DW  long-latency result
- we  out  1  register-file write enable
- waddr  out  AW  register-file write address
- wdata  out  DW  register-file write data
- raddr1, raddr2  in  AW  decode source addresses to check
- pend1, pend2  out  1  a buffered write to raddrN exists
- stall_req  out  1  request to hold pipeline write-back for one cycle

## Operation
- Outputs selected combinationally each cycle:
  - pipe_we=1: we=1, waddr=pipe_waddr, wdata=pipe_wdata.
  - Else FIFO non-empty: we=1, waddr/wdata from FIFO head; head pops at posedge.
  - Else: we=0, waddr=0, wdata=0.
- Address 0 is never written: we=0 whenever the selected address is 0.
- Enqueue: lr_valid && lr_ready at posedge. lr_ready = !full (no same-cycle pass-through when full).
- lr_waddr=0 is accepted (handshake completes) but not enqueued.
- FIFO: read/write pointers of clog2(DEPTH) bits, wrap modulo DEPTH. Count of clog2(DEPTH)+1 bits, range 0..DEPTH.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- pendN = 1 iff raddrN != 0 and any occupied entry has waddr == raddrN. Purely combinational from FIFO state. lr_* inputs not yet accepted are not considered.
- Ordering contract: the pipeline must not write-back a register with pending=1 (WAW). Decode stalls on pendN for destinations and sources. The bench asserts this.
- Reset: FIFO empty, pointers and count 0, starvation counter 0.
  - While rst=1: we=0, waddr=0, wdata=0, lr_ready=0, pend1=pend2=0, stall_req=0.
  - Entries in flight when rst asserts are discarded.

## Timing
- Pipeline path: zero latency, input to we/waddr/wdata in the same cycle.
- Long-latency path: minimum 1 cycle from acceptance to write (entry visible at head the cycle after the accept edge).
- FIFO drains at one entry per cycle when pipe_we=0.
- pendN rises the cycle after acceptance. It falls the cycle after the drain edge of the last matching entry.
- lr_ready is a function of registered count only; it never depends on lr_valid.

## Configuration
- WB_STARVE_EN defined:
  - A saturating counter increments each cycle the FIFO is non-empty and pipe_we=1; it clears on any drain or when empty.
  - When the counter reaches STARVE_MAX, registered stall_req=1 for exactly one cycle.
  - The pipeline guarantees pipe_we=0 in that cycle, so the head drains; the counter clears.
  - If pipe_we=1 anyway, pipeline priority still holds and stall_req re-asserts the next cycle.
- WB_STARVE_EN undefined: counter absent, stall_req tied 0; draining is purely opportunistic.

## Structure
- Shared defines file (existing): RstEnable, WriteEnable, register address and data bus widths, and a new WB_FIFO_DEPTH default.
- Sub-module wb_fifo: storage, pointers, count, full/empty, and per-entry address compare producing pend outputs.
- wb_arbiter holds the output mux and the starvation logic.

## Test plan
- Reset then idle: we=0, lr_ready=1, pend1=pend2=0.
- Priority: FIFO holds (r5, 0xAAAA0005) while pipe_we=1 to (r3, 0x33) for 3 cycles -> three writes to r3. r5 written on the first pipe_we=0 cycle; pend1 (raddr1=5) high until the cycle after that write.
- Full/backpressure (DEPTH=4): 5 back-to-back lr_valid with pipe_we=1 -> 4 accepted, lr_ready=0 on the 5th. One drain -> lr_ready=1 next cycle, 5th accepted. Drain order is FIFO.
- Wrap and simultaneous: 10 enqueues interleaved with drains so the pointers wrap twice. Same-cycle enqueue+dequeue keeps count constant. Data written matches submission order.
- Address 0: lr_waddr=0 accepted, count unchanged, no write. pipe_waddr=0 with pipe_we=1 -> we=0, and a pending FIFO head drains that cycle.
- WB_STARVE_EN, STARVE_MAX=8: FIFO non-empty with pipe_we held 1 -> stall_req pulses in cycle 9. With pipe_we=0 that cycle, the head drains. Mid-run rst -> FIFO empty and stall_req=0 the next cycle.
